charge_scheduler: RTL

Shares one fee-computation datapath between NUM_GATES exit gates. It arbitrates fee requests round-robin, latches the winning gate's entry and exit times and the current price, and computes value = floor(duration / 60) * price. The computation is sequential: the divide uses iterative subtraction and the multiply uses shift-add. It returns a saturated result with a per-gate acknowledge pulse. It sits between the exit-gate controllers and the display/payment logic.

---
 rtl/charge_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/charge_scheduler.sv
// charge_scheduler
//   Shares one fee datapath between NUM_GATES exit gates. Requests are
//   arbitrated round-robin; the winner's entry/exit times and the current
//   price are latched, then value = floor(duration / UNIT_MIN) * price is
//   computed by iterative subtraction followed by shift-add multiplication.
//   The result saturates at 2^VALUE_W-1 and is returned with a one-cycle
//   done pulse and a matching per-gate ack pulse.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high reset
//   req         per-gate fee request (level, held until ack)
//   start_time  packed entry times, gate g at [g*TIME_W +: TIME_W]
//   end_time    packed exit times, same packing
//   price       shared price per unit, sampled in LATCH
//   ack         one-cycle pulse to the served gate, coincident with done
//   done        one-cycle pulse: value/overflow/grant_id valid
//   value       computed charge, held until next done
//   overflow    product exceeded 2^VALUE_W-1, held with value
//   grant_id    index of gate being / last served
//   busy        high in every state except IDLE
module charge_scheduler #(
    parameter int NUM_GATES = 2,
    parameter int TIME_W    = 11,
    parameter int PRICE_W   = 7,
    parameter int VALUE_W   = 11,
    parameter int UNIT_MIN  = 60
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_GATES-1:0]        req,
    input  logic [NUM_GATES*TIME_W-1:0] start_time,
    input  logic [NUM_GATES*TIME_W-1:0] end_time,
    input  logic [PRICE_W-1:0]          price,
    output logic [NUM_GATES-1:0]        ack,
    output logic                        done,
    output logic [VALUE_W-1:0]          value,
    output logic                        overflow,
    output logic [1:0]                  grant_id,
    output logic                        busy
);

    localparam int Q_W   = 6;
    localparam int ACC_W = Q_W + PRICE_W;
    localparam int CNT_W = $clog2(PRICE_W + 1);

    localparam logic [TIME_W-1:0] UNIT = TIME_W'(UNIT_MIN);
    localparam logic [ACC_W-1:0]  VMAX = ACC_W'((64'd1 << VALUE_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_DIVIDE,
        S_MULTIPLY,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [1:0]           ptr;
    logic [NUM_GATES-1:0] served_mask;
    logic [TIME_W-1:0]    rem;
    logic [Q_W-1:0]       quo;
    logic [PRICE_W-1:0]   price_l;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     mcand;
    logic [PRICE_W-1:0]   mpr;
    logic [CNT_W-1:0]     mcnt;

    logic [NUM_GATES-1:0] cand;
    logic                 found;
    logic [1:0]           pick;
    logic                 mul_last;
    logic [ACC_W-1:0]     acc_sum;
    logic [TIME_W-1:0]    dur;
    logic [NUM_GATES-1:0] grant_onehot;

    // The gate served last is hidden for one IDLE cycle so its still-high
    // request (dropped one cycle after ack) cannot cause a second service.
    assign cand         = req & ~served_mask;
    assign mul_last     = (mcnt == CNT_W'(PRICE_W - 1));
    assign acc_sum      = acc + (mpr[0] ? mcand : '0);
    assign dur          = end_time[int'(grant_id)*TIME_W +: TIME_W]
                        - start_time[int'(grant_id)*TIME_W +: TIME_W];
    assign grant_onehot = NUM_GATES'(1) << grant_id;

    // Round-robin: first candidate at or after the pointer, cyclically.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_GATES; i++) begin
            idx = (32'(ptr) + i) % NUM_GATES;
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = 2'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (found) state_nxt = S_LATCH;
            S_LATCH:    state_nxt = S_DIVIDE;
            S_DIVIDE:   if (rem < UNIT) state_nxt = S_MULTIPLY;
            S_MULTIPLY: if (mul_last) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack         <= '0;
            done        <= 1'b0;
            value       <= '0;
            overflow    <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            ptr         <= '0;
            served_mask <= '0;
            rem         <= '0;
            quo         <= '0;
            price_l     <= '0;
            acc         <= '0;
            mcand       <= '0;
            mpr         <= '0;
            mcnt        <= '0;
        end else begin
            done <= 1'b0;
            ack  <= '0;
            busy <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    served_mask <= '0;
                    if (found) grant_id <= pick;
                end
                S_LATCH: begin
                    rem     <= dur;
                    quo     <= '0;
                    price_l <= price;
                end
                S_DIVIDE: begin
                    if (rem >= UNIT) begin
                        rem <= rem - UNIT;
                        quo <= quo + Q_W'(1);
                    end else begin
                        acc   <= '0;
                        mcand <= ACC_W'(quo);
                        mpr   <= price_l;
                        mcnt  <= '0;
                    end
                end
                S_MULTIPLY: begin
                    acc   <= acc_sum;
                    mcand <= mcand << 1;
                    mpr   <= mpr >> 1;
                    mcnt  <= mcnt + CNT_W'(1);
                    // Result is registered on the last step so that done,
                    // ack and value all appear together in the DONE cycle.
                    if (mul_last) begin
                        done <= 1'b1;
                        ack  <= grant_onehot;
                        if (acc_sum > VMAX) begin
                            value    <= '1;
                            overflow <= 1'b1;
                        end else begin
                            value    <= VALUE_W'(acc_sum);
                            overflow <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    ptr         <= (grant_id == 2'(NUM_GATES - 1)) ? 2'd0 : grant_id + 2'd1;
                    served_mask <= grant_onehot;
                end
                default: ;
            endcase
        end
    end

endmodule
